// File: rtl/pipe_pkg.sv
// Shared scoreboard constants and the layout of the saved pre-issue entry used by kill/restore.
// Build option HAZ_FORWARD_EN adds the bypass-availability count to the saved record.
package pipe_pkg;
    localparam int REG_NUM    = 32;
    localparam int REG_AW     = 5;
    localparam logic [REG_AW-1:0] ZERO_REG = '0;
    localparam int SAVE_LAT_W = 8;

    typedef struct packed {
        logic [REG_AW-1:0]     dst;
        logic [SAVE_LAT_W-1:0] cnt_wb;
`ifdef HAZ_FORWARD_EN
        logic [SAVE_LAT_W-1:0] cnt_byp;
`endif
    } sb_save_t;

    function automatic logic [SAVE_LAT_W-1:0] sat_dec(input logic [SAVE_LAT_W-1:0] v);
        return (v == '0) ? '0 : v - SAVE_LAT_W'(1);
    endfunction
endpackage

// File: rtl/pipe_sb_entry.sv
// One register's in-flight write counters: load on issue, restore on kill, else count down to 0.
// Registered, one-cycle update; no backpressure. HAZ_FORWARD_EN adds the bypass counter.
module pipe_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_load_wb,
    input  logic             i_restore,
    input  logic [LAT_W-1:0] i_rest_wb,
`ifdef HAZ_FORWARD_EN
    input  logic [LAT_W-1:0] i_load_byp,
    input  logic [LAT_W-1:0] i_rest_byp,
`endif
    output logic [LAT_W-1:0] o_cnt_wb,
    output logic [LAT_W-1:0] o_cnt_byp
);
    logic [LAT_W-1:0] r_cnt_wb;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt_wb <= '0;
        else if (i_load)
            r_cnt_wb <= i_load_wb;
        else if (i_restore)
            r_cnt_wb <= i_rest_wb;
        else if (r_cnt_wb != '0)
            r_cnt_wb <= r_cnt_wb - LAT_W'(1);
    end

    assign o_cnt_wb = r_cnt_wb;

`ifdef HAZ_FORWARD_EN
    logic [LAT_W-1:0] r_cnt_byp;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt_byp <= '0;
        else if (i_load)
            r_cnt_byp <= i_load_byp;
        else if (i_restore)
            r_cnt_byp <= i_rest_byp;
        else if (r_cnt_byp != '0)
            r_cnt_byp <= r_cnt_byp - LAT_W'(1);
    end

    assign o_cnt_byp = r_cnt_byp;
`else
    assign o_cnt_byp = '0;
`endif
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Decode-stage RAW/WAW stall generator over a 32-entry latency scoreboard, with kill/restore of the last issue.
// Stall is combinational in the issue cycle; HAZ_FORWARD_EN switches RAW to bypass timing and drives fwd_hit/fwd_age.
module pipe_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 3,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_wena,
    input  logic [4:0]               issue_dst,
    input  logic [LAT_W-1:0]         issue_lat,
    input  logic [LAT_W-1:0]         issue_byp,
    input  logic [NUM_SRC*5-1:0]     src_addr,
    input  logic [NUM_SRC-1:0]       src_rena,
    input  logic                     kill,
    output logic                     stall,
    output logic [NUM_SRC-1:0]       fwd_hit,
    output logic [NUM_SRC*LAT_W-1:0] fwd_age,
    output logic [31:0]              pending_mask,
    output logic [CNT_W-1:0]         stall_cycles
);
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    logic [LAT_W-1:0]      w_cnt_wb  [REG_NUM];
    logic [LAT_W-1:0]      w_cnt_byp [REG_NUM];
    logic [NUM_SRC-1:0]    w_raw;
    logic                  w_waw;
    logic                  w_accept;
    logic                  w_wr;
    logic                  w_kill;
    logic [SAVE_LAT_W-1:0] w_dec_wb;
    logic [LAT_W-1:0]      w_rest_wb;
    sb_save_t              r_save;
    logic                  r_save_vld;
    logic [CNT_W-1:0]      r_stall_cycles;

    assign w_accept = issue_valid && !stall;
    assign w_wr     = w_accept && issue_wena;
    assign w_kill   = kill && r_save_vld;

    // Saved counts always came from LAT_W-bit counters, so the clamp only guards the wider record.
    assign w_dec_wb  = sat_dec(r_save.cnt_wb);
    assign w_rest_wb = (w_dec_wb > SAVE_LAT_W'(LAT_MAX)) ? LAT_MAX : w_dec_wb[LAT_W-1:0];

`ifdef HAZ_FORWARD_EN
    logic [SAVE_LAT_W-1:0] w_dec_byp;
    logic [LAT_W-1:0]      w_rest_byp;
    assign w_dec_byp  = sat_dec(r_save.cnt_byp);
    assign w_rest_byp = (w_dec_byp > SAVE_LAT_W'(LAT_MAX)) ? LAT_MAX : w_dec_byp[LAT_W-1:0];
`endif

    for (genvar r = 0; r < REG_NUM; r++) begin : g_entry
        logic w_load;
        logic w_restore;
        assign w_load    = w_wr && (issue_dst == REG_AW'(r)) && (r != 0);
        assign w_restore = w_kill && (r_save.dst == REG_AW'(r)) && (r != 0);

        pipe_sb_entry #(.LAT_W(LAT_W)) u_entry (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_load),
            .i_load_wb  (issue_lat),
            .i_restore  (w_restore),
            .i_rest_wb  (w_rest_wb),
`ifdef HAZ_FORWARD_EN
            .i_load_byp (issue_byp),
            .i_rest_byp (w_rest_byp),
`endif
            .o_cnt_wb   (w_cnt_wb[r]),
            .o_cnt_byp  (w_cnt_byp[r])
        );

        assign pending_mask[r] = (w_cnt_wb[r] != '0);
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] w_src;
        logic              w_rd;
        assign w_src = src_addr[5*i +: 5];
        assign w_rd  = src_rena[i] && (w_src != ZERO_REG);
`ifdef HAZ_FORWARD_EN
        assign w_raw[i]              = w_rd && (w_cnt_byp[w_src] != '0);
        assign fwd_hit[i]            = w_rd && (w_cnt_byp[w_src] == '0) && (w_cnt_wb[w_src] != '0);
        assign fwd_age[i*LAT_W +: LAT_W] = w_cnt_wb[w_src];
`else
        assign w_raw[i] = w_rd && (w_cnt_wb[w_src] != '0);
`endif
    end

`ifndef HAZ_FORWARD_EN
    assign fwd_hit = '0;
    assign fwd_age = '0;
`endif

    // A younger write must not retire before an older one to the same register.
    assign w_waw = issue_wena && (issue_dst != ZERO_REG) && (w_cnt_wb[issue_dst] > issue_lat);
    assign stall = issue_valid && (|w_raw || w_waw);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_save     <= '0;
            r_save_vld <= 1'b0;
        end else begin
            r_save_vld <= w_wr;
            if (w_wr) begin
                r_save.dst    <= issue_dst;
                r_save.cnt_wb <= SAVE_LAT_W'(w_cnt_wb[issue_dst]);
`ifdef HAZ_FORWARD_EN
                r_save.cnt_byp <= SAVE_LAT_W'(w_cnt_byp[issue_dst]);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (stall)
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end

    assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed-vector bench for pipe_hazard_scoreboard; expectations hand-derived from counter load/decrement timing.
module tb_pipe_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_wena;
    logic [4:0]  issue_dst;
    logic [2:0]  issue_lat;
    logic [2:0]  issue_byp;
    logic [9:0]  src_addr;
    logic [1:0]  src_rena;
    logic        kill;
    logic        stall;
    logic [1:0]  fwd_hit;
    logic [5:0]  fwd_age;
    logic [31:0] pending_mask;
    logic [31:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stall;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard #(.NUM_SRC(2), .LAT_W(3), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_wena   (issue_wena),
        .issue_dst    (issue_dst),
        .issue_lat    (issue_lat),
        .issue_byp    (issue_byp),
        .src_addr     (src_addr),
        .src_rena     (src_rena),
        .kill         (kill),
        .stall        (stall),
        .fwd_hit      (fwd_hit),
        .fwd_age      (fwd_age),
        .pending_mask (pending_mask),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_wena  = 1'b0;
        issue_dst   = 5'd0;
        issue_lat   = 3'd0;
        issue_byp   = 3'd0;
        src_addr    = 10'd0;
        src_rena    = 2'b00;
        kill        = 1'b0;
    endtask

    task automatic issue(input logic [4:0] d, input logic [2:0] lat, input logic [2:0] byp);
        issue_valid = 1'b1;
        issue_wena  = 1'b1;
        issue_dst   = d;
        issue_lat   = lat;
        issue_byp   = byp;
    endtask

    task automatic read0(input logic [4:0] s);
        src_addr[4:0] = s;
        src_rena[0]   = 1'b1;
    endtask

    // Holds inputs steady and counts consecutive stalled cycles, bounded.
    task automatic count_stall(output int n);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (!stall) break;
            n++;
            tick();
            #1;
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pending", pending_mask, 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        rst = 1'b0;

        // Load $5 lat=3, then a reader: stalls while cnt is 3,2,1.
        tick(); idle(); issue(5'd5, 3'd3, 3'd3); #1;
        chk("raw_issue_stall", 32'(stall), 32'd0);
        tick(); idle(); issue_valid = 1'b1; read0(5'd5); #1;
        chk("raw_pending5", pending_mask, 32'h20);
        count_stall(n_stall);
        chk("raw_stall_len", 32'(n_stall), 32'd3);
`ifdef HAZ_FORWARD_EN
        chk("raw_fwd_after", 32'(fwd_hit), 32'd0);
`endif
        tick(); idle(); #1;
        chk("raw_drained", pending_mask, 32'd0);
        chk("raw_perf", stall_cycles, 32'd3);

        // Hazard seen on port 1; no stall without issue_valid.
        tick(); idle(); issue(5'd3, 3'd2, 3'd2); #1;
        tick(); idle(); src_addr[9:5] = 5'd3; src_rena[1] = 1'b1; #1;
        chk("novalid_stall", 32'(stall), 32'd0);
        issue_valid = 1'b1; #1;
        chk("port1_stall", 32'(stall), 32'd1);
        tick(); idle(); #1;
        chk("port1_perf", stall_cycles, 32'd4);
        chk("port1_pending3", pending_mask, 32'h8);

        // WAW: mul $9 lat=6 then ALU $9 lat=2 stalls while cnt is 6,5,4,3.
        tick(); idle(); issue(5'd9, 3'd6, 3'd6); #1;
        chk("waw_first_stall", 32'(stall), 32'd0);
        tick(); idle(); issue(5'd9, 3'd2, 3'd2); #1;
        count_stall(n_stall);
        chk("waw_stall_len", 32'(n_stall), 32'd4);
        tick(); idle(); #1;
        chk("waw_pending9", pending_mask, 32'h200);
        tick(); tick(); #1;
        chk("waw_drained", pending_mask, 32'd0);
        chk("waw_perf", stall_cycles, 32'd8);

        // Register 0 is never pending nor a hazard.
        tick(); idle(); issue(5'd0, 3'd5, 3'd5); read0(5'd0); src_rena[1] = 1'b1; #1;
        chk("zero_issue_stall", 32'(stall), 32'd0);
        tick(); idle(); issue_valid = 1'b1; read0(5'd0); #1;
        chk("zero_pending", pending_mask, 32'd0);
        chk("zero_read_stall", 32'(stall), 32'd0);
        chk("zero_fwd_hit", 32'(fwd_hit), 32'd0);

        // $4 lat=4, re-issued lat=2 when cnt=2, then killed: restores to 2-1=1.
        tick(); idle(); issue(5'd4, 3'd4, 3'd4); #1;
        tick(); idle(); #1;
        tick(); #1;
        tick(); issue(5'd4, 3'd2, 3'd2); #1;
        chk("kill_reissue_stall", 32'(stall), 32'd0);
        tick(); idle(); kill = 1'b1; #1;
        tick(); idle(); #1;
        chk("kill_pending4", pending_mask, 32'h10);
        tick(); #1;
        chk("kill_drained4", pending_mask, 32'd0);

        // Kill of a write to an idle register restores 0.
        tick(); idle(); issue(5'd7, 3'd3, 3'd3); #1;
        tick(); idle(); kill = 1'b1; #1;
        tick(); idle(); #1;
        chk("kill_to_zero", pending_mask, 32'd0);

        // Kill one cycle too late: saved entry no longer valid, no effect.
        tick(); idle(); issue(5'd7, 3'd3, 3'd3); #1;
        tick(); idle(); #1;
        tick(); idle(); kill = 1'b1; #1;
        tick(); idle(); #1;
        chk("kill_stale", pending_mask, 32'h80);
        tick(); #1;

        // Kill together with a new issue to the same register: new issue wins.
        tick(); idle(); issue(5'd6, 3'd2, 3'd2); #1;
        tick(); idle(); kill = 1'b1; issue(5'd6, 3'd3, 3'd3); #1;
        chk("kill_accept_stall", 32'(stall), 32'd0);
        tick(); idle(); #1;
        tick(); #1;
        tick(); #1;
        chk("kill_accept_pending6", pending_mask, 32'h40);
        tick(); #1;
        chk("kill_accept_drained", pending_mask, 32'd0);

`ifdef HAZ_FORWARD_EN
        // ALU $8 lat=3 byp=1: one stall while cnt_byp=1, then bypass with age 2.
        tick(); idle(); issue(5'd8, 3'd3, 3'd1); #1;
        tick(); idle(); issue_valid = 1'b1; read0(5'd8); #1;
        chk("fwd_byp_stall", 32'(stall), 32'd1);
        chk("fwd_hit_early", 32'(fwd_hit), 32'd0);
        tick(); #1;
        chk("fwd_no_stall", 32'(stall), 32'd0);
        chk("fwd_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_age", 32'(fwd_age[2:0]), 32'd2);
        tick(); idle(); #1;
        tick(); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
